// File: rtl/cam_pkg.sv
// Shared types for the camera pixel assembler.
// Pixel word, buffer entry and capture state.
package cam_pkg;

  typedef logic [15:0] pixel_t;

  typedef struct packed {
    logic   newframe;
    pixel_t pixel;
  } entry_t;

  typedef enum logic {
    WAIT_VS = 1'b0,
    ACTIVE  = 1'b1
  } state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous first-word-fall-through pixel buffer.
// Head entry is driven straight from storage; zero while empty.
module pixel_fifo
  import cam_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  entry_t wdata,
  input  logic   pop,
  output entry_t rdata,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  entry_t         mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a full buffer needs.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/camera_pixel_assembler.sv
// Pairs camera bytes into RGB565 pixels on PCLK edges
// and buffers them for a valid/ready consumer.
module camera_pixel_assembler
  import cam_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter bit HI_BYTE_FIRST = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        camera_pclk_in,
  input  logic        camera_hs_in,
  input  logic        camera_vs_in,
  input  logic [7:0]  camera_d_in,
  output logic        valid_out,
  input  logic        ready_in,
  output logic [15:0] data_out,
  output logic        newframe_out,
  output logic        overflow_out,
  output logic [15:0] frame_count_out
);

  state_t      state;
  logic        pclk_q;
  logic        phase;
  logic        pending;
  logic [7:0]  byte_q;
  logic [15:0] frame_count;
  logic        overflow;

  logic        pclk_edge;
  logic        pair_done;
  logic        pop;
  logic        drop;
  logic        full;
  logic        empty;
  entry_t      head;
  entry_t      wdata;

  assign pclk_edge = camera_pclk_in && !pclk_q;
  assign pair_done = pclk_edge && (state == ACTIVE) &&
                     !camera_vs_in && camera_hs_in && phase;
  assign pop       = valid_out && ready_in;
  assign drop      = pair_done && full && !pop;

  always_comb begin
    wdata          = '0;
    wdata.newframe = pending;
    wdata.pixel    = HI_BYTE_FIRST ? {byte_q, camera_d_in}
                                   : {camera_d_in, byte_q};
  end

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_in),
    .rst_n (rst_in),
    .push  (pair_done),
    .wdata (wdata),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign valid_out       = !empty;
  assign data_out        = head.pixel;
  assign newframe_out    = head.newframe;
  assign overflow_out    = overflow;
  assign frame_count_out = frame_count;

  // pclk_q resets high so a PCLK already high at release is no edge.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state       <= WAIT_VS;
      pclk_q      <= 1'b1;
      phase       <= 1'b0;
      pending     <= 1'b0;
      byte_q      <= '0;
      frame_count <= '0;
      overflow    <= 1'b0;
    end else begin
      pclk_q <= camera_pclk_in;
      if (drop) overflow <= 1'b1;
      if (pop && head.newframe) frame_count <= frame_count + 16'd1;
      if (pclk_edge) begin
        unique case (state)
          WAIT_VS: begin
            if (camera_vs_in) begin
              state   <= ACTIVE;
              pending <= 1'b1;
              phase   <= 1'b0;
            end
          end
          ACTIVE: begin
            if (camera_vs_in) begin
              phase   <= 1'b0;
              pending <= 1'b1;
            end else if (!camera_hs_in) begin
              phase <= 1'b0;
            end else if (!phase) begin
              byte_q <= camera_d_in;
              phase  <= 1'b1;
            end else begin
              phase <= 1'b0;
              // A dropped frame-start keeps the flag for the next pixel.
              if (!drop) pending <= 1'b0;
            end
          end
          default: state <= WAIT_VS;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_camera_pixel_assembler.sv
// Randomized and directed bench for camera_pixel_assembler
// against a byte-level reference model.
module tb_camera_pixel_assembler;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pclk = 1'b1;
  logic        hs = 1'b0;
  logic        vs = 1'b0;
  logic [7:0]  d = 8'h00;
  logic        ready = 1'b1;
  logic        valid_out;
  logic [15:0] data_out;
  logic        newframe_out;
  logic        overflow_out;
  logic [15:0] frame_count_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  camera_pixel_assembler #(
    .FIFO_DEPTH    (DEPTH),
    .HI_BYTE_FIRST (1'b1)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst_n),
    .camera_pclk_in  (pclk),
    .camera_hs_in    (hs),
    .camera_vs_in    (vs),
    .camera_d_in     (d),
    .valid_out       (valid_out),
    .ready_in        (ready),
    .data_out        (data_out),
    .newframe_out    (newframe_out),
    .overflow_out    (overflow_out),
    .frame_count_out (frame_count_out)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // Reference model: bytes -> pixels -> bounded queue.
  bit          m_prev;
  bit          m_sync;
  int          m_half;
  bit          m_pend;
  bit          m_ovf;
  int unsigned m_fc;
  logic [16:0] mq[$];
  logic [16:0] dlog[$];

  always @(posedge clk or negedge rst_n) begin
    bit          edge_s;
    bit          pop_s;
    bit          full_s;
    bit          have;
    logic [16:0] px;
    if (!rst_n) begin
      m_prev = 1'b1;
      m_sync = 1'b0;
      m_half = -1;
      m_pend = 1'b0;
      m_ovf  = 1'b0;
      m_fc   = 0;
      mq.delete();
    end else begin
      have   = 1'b0;
      px     = '0;
      edge_s = pclk && !m_prev;
      m_prev = pclk;
      if (edge_s) begin
        if (vs) begin
          m_sync = 1'b1;
          m_half = -1;
          m_pend = 1'b1;
        end else if (m_sync) begin
          if (!hs) m_half = -1;
          else if (m_half < 0) m_half = int'(d);
          else begin
            px     = {m_pend, m_half[7:0], d};
            have   = 1'b1;
            m_half = -1;
          end
        end
      end
      full_s = (mq.size() >= DEPTH);
      pop_s  = (mq.size() > 0) && ready;
      if (pop_s) begin
        if (mq[0][16]) m_fc = (m_fc + 1) % 65536;
        void'(mq.pop_front());
      end
      if (have) begin
        if (!full_s || pop_s) begin
          mq.push_back(px);
          m_pend = 1'b0;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit ev;
    ev = (mq.size() != 0);
    chk("valid", 32'(valid_out), 32'(ev));
    if (ev) begin
      chk("data", 32'(data_out), 32'(mq[0][15:0]));
      chk("newframe", 32'(newframe_out), 32'(mq[0][16]));
    end
    chk("overflow", 32'(overflow_out), 32'(m_ovf));
    chk("frame_count", 32'(frame_count_out), m_fc);
    if (valid_out && ready) dlog.push_back({newframe_out, data_out});
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(input bit v, input bit h, input logic [7:0] b);
    pclk = 1'b0;
    vs   = v;
    hs   = h;
    d    = b;
    tick(1 + int'($urandom % 2));
    pclk = 1'b1;
    tick(1);
  endtask

  task automatic pix(input logic [15:0] p);
    send(1'b0, 1'b1, p[15:8]);
    send(1'b0, 1'b1, p[7:0]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    dlog.delete();
  endtask

  task automatic chk_log(input string nm, input int idx,
                         input logic [16:0] exp);
    if (idx < dlog.size()) chk(nm, 32'(dlog[idx]), 32'(exp));
    else chk(nm, 32'hDEAD_BEEF, 32'(exp));
  endtask

  initial begin
    #1;
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_nf", 32'(newframe_out), 32'd0);
    chk("rst_ovf", 32'(overflow_out), 32'd0);
    chk("rst_fc", 32'(frame_count_out), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Bytes before any VSYNC are ignored.
    for (int i = 0; i < 6; i++) send(1'b0, 1'b1, 8'(8'h40 + i));
    send(1'b0, 1'b0, 8'h00);
    tick(4);
    chk("prevs_cnt", 32'(dlog.size()), 32'd0);
    chk("prevs_ovf", 32'(overflow_out), 32'd0);

    // Basic frame.
    ready = 1'b1;
    send(1'b1, 1'b0, 8'h00);
    pix(16'hABCD);
    pix(16'h1234);
    send(1'b0, 1'b0, 8'h00);
    tick(4);
    chk("basic_cnt", 32'(dlog.size()), 32'd2);
    chk_log("basic_p0", 0, 17'h1ABCD);
    chk_log("basic_p1", 1, 17'h01234);
    chk("basic_fc", 32'(frame_count_out), 32'd1);

    // Odd byte dropped at line end.
    dlog.delete();
    pix(16'hABCD);
    send(1'b0, 1'b1, 8'hEF);
    send(1'b0, 1'b0, 8'h00);
    pix(16'h1122);
    send(1'b0, 1'b0, 8'h00);
    tick(4);
    chk("odd_cnt", 32'(dlog.size()), 32'd2);
    chk_log("odd_p0", 0, 17'h0ABCD);
    chk_log("odd_p1", 1, 17'h01122);

    // Back-pressure and overflow.
    do_reset();
    chk("ovf_clear", 32'(overflow_out), 32'd0);
    ready = 1'b0;
    send(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++)
      pix({8'(8'h10 + 2 * i), 8'(8'h11 + 2 * i)});
    send(1'b0, 1'b0, 8'h00);
    chk("bp_valid", 32'(valid_out), 32'd1);
    chk("bp_data", 32'(data_out), 32'h1011);
    chk("bp_ovf", 32'(overflow_out), 32'd1);
    tick(5);
    chk("bp_hold", 32'(data_out), 32'h1011);
    ready = 1'b1;
    tick(10);
    chk("bp_cnt", 32'(dlog.size()), 32'd4);
    chk_log("bp_p0", 0, 17'h11011);
    chk_log("bp_p1", 1, 17'h01213);
    chk_log("bp_p2", 2, 17'h01415);
    chk_log("bp_p3", 3, 17'h01617);

    // Frame-start pixel dropped; flag moves to next accepted pixel.
    do_reset();
    ready = 1'b0;
    send(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++)
      pix({8'(8'h20 + 2 * i), 8'(8'h21 + 2 * i)});
    send(1'b1, 1'b0, 8'h00);
    pix(16'hA0A1);
    send(1'b0, 1'b0, 8'h00);
    ready = 1'b1;
    tick(10);
    pix(16'hB0B1);
    send(1'b0, 1'b0, 8'h00);
    tick(4);
    chk("nfd_cnt", 32'(dlog.size()), 32'd5);
    chk_log("nfd_p0", 0, 17'h12021);
    chk_log("nfd_p3", 3, 17'h02627);
    chk_log("nfd_p4", 4, 17'h1B0B1);
    chk("nfd_fc", 32'(frame_count_out), 32'd2);

    // Reset mid-pair with buffered pixels, PCLK high at release.
    do_reset();
    ready = 1'b0;
    send(1'b1, 1'b0, 8'h00);
    pix(16'h3132);
    pix(16'h3334);
    send(1'b0, 1'b1, 8'h55);
    chk("mr_pre", 32'(valid_out), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(valid_out), 32'd0);
    dlog.delete();
    tick(2);
    vs = 1'b1;
    hs = 1'b1;
    rst_n = 1'b1;
    tick(3);
    ready = 1'b1;
    for (int i = 0; i < 4; i++) send(1'b0, 1'b1, 8'(8'h60 + i));
    send(1'b0, 1'b0, 8'h00);
    tick(4);
    chk("mr_none", 32'(dlog.size()), 32'd0);
    send(1'b1, 1'b0, 8'h00);
    pix(16'h7788);
    send(1'b0, 1'b0, 8'h00);
    tick(4);
    chk("mr_cnt", 32'(dlog.size()), 32'd1);
    chk_log("mr_p0", 0, 17'h17788);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      ready = ($urandom % 3) != 0;
      send(($urandom % 40) == 0, ($urandom % 8) != 0, 8'($urandom));
    end
    ready = 1'b1;
    send(1'b0, 1'b0, 8'h00);
    tick(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/camera_pixel_assembler.md
CAMERA_PIXEL_ASSEMBLER -- requirements
Module: camera_pixel_assembler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning pixel buffer entries (power of two, >=2).
REQ-002 SHALL have parameter HI_BYTE_FIRST, default 1, meaning the first byte of each pair is pixel bits [15:8].
REQ-003 clk_in  input  1  system clock; the only clock.
REQ-004 rst_in  input  1  reset, asynchronous, active-low.
REQ-005 camera_pclk_in  input  1  camera pixel clock, already synchronized to clk_in, sampled as data.
REQ-006 camera_hs_in  input  1  HREF, high during active line bytes.
REQ-007 camera_vs_in  input  1  VSYNC, high between frames.
REQ-008 camera_d_in  input  8  camera data byte.
REQ-009 valid_out  output  1  pixel available.
REQ-010 ready_in  input  1  downstream packer accepts pixel.
REQ-011 data_out  output  16  RGB565 pixel.
REQ-012 newframe_out  output  1  pixel is first of a frame.
REQ-013 overflow_out  output  1  sticky: a pixel was dropped.
REQ-014 frame_count_out  output  16  frames started (newframe pixels accepted downstream).

Function
REQ-015 SHALL detect PCLK rising edge as camera_pclk_in==1 and registered previous value==0; all camera inputs sampled only in that cycle.
REQ-016 SHALL implement states WAIT_VS and ACTIVE; after reset state is WAIT_VS; all bytes discarded in WAIT_VS.
REQ-017 WAIT_VS -> ACTIVE on the first PCLK edge with camera_vs_in==1; pending_newframe set.
REQ-018 In ACTIVE, PCLK edge with hs==1, phase==0: store byte, phase<=1.
REQ-019 In ACTIVE, PCLK edge with hs==1, phase==1: form pixel from stored and current byte per HI_BYTE_FIRST, push to buffer, phase<=0.
REQ-020 PCLK edge with hs==0: phase<=0; a stored odd byte is discarded.
REQ-021 PCLK edge with vs==1: phase<=0, pending_newframe<=1; vs takes priority over hs.
REQ-022 First pixel pushed while pending_newframe==1 SHALL carry newframe=1 and clear pending_newframe.
REQ-023 Buffer SHALL be first-word-fall-through: valid_out=!empty, data_out/newframe_out from head, combinational from buffer registers.
REQ-024 Latency: pixel visible on valid_out the cycle after the clk_in cycle in which its second byte was sampled.
REQ-025 Pop when valid_out && ready_in; while valid_out && !ready_in, data_out and newframe_out SHALL hold stable.
REQ-026 Push when full and no pop: pixel dropped, overflow_out<=1 (sticky until reset); if dropped pixel had newframe=1, pending_newframe stays 1.
REQ-027 Push when full with simultaneous pop: push accepted, no drop.
REQ-028 Push and pop same cycle when empty: pixel is not visible until the next cycle (no bypass).
REQ-029 frame_count_out SHALL increment on each pop with newframe_out==1, wrapping 16'hFFFF -> 0.

Reset
REQ-030 On rst_in low, asynchronously: state WAIT_VS, phase 0, buffer empty, valid_out 0, newframe_out 0, data_out 0, overflow_out 0, frame_count_out 0, pending_newframe 0.
REQ-031 Registered previous-PCLK SHALL reset to 1, so PCLK high at reset release is not an edge.
REQ-032 Reset mid-line or mid-pair SHALL discard all partial and buffered pixels; operation resumes only after the next VSYNC.

Structure
REQ-033 Package cam_pkg SHALL hold pixel_t (16-bit), buffer entry struct {newframe, pixel}, and the state enum.
REQ-034 Buffer SHALL be sub-module pixel_fifo (sync FWFT FIFO, parameter DEPTH, full/empty, same reset).

Verification
REQ-035 Reset, vs pulse, line of bytes AB,CD,12,34 with ready_in=1 -> pixels 16'hABCD (newframe=1), 16'h1234 (newframe=0); frame_count_out=1.
REQ-036 Bytes before first vs -> no valid_out; overflow_out stays 0.
REQ-037 Line of 3 bytes AB,CD,EF then hs low, next line 11,22 -> pixels ABCD, 1122 only; EF discarded.
REQ-038 ready_in=0 for 6 pixels, FIFO_DEPTH=4 -> 4 pixels held, overflow_out=1, data_out stable; ready_in=1 -> exactly first 4 pixels in order.
REQ-039 newframe pixel dropped on full, then space freed -> next accepted pixel carries newframe=1.
REQ-040 rst_in low mid-pair with 2 buffered pixels -> valid_out=0 immediately; no output until next vs; PCLK held high at release gives no edge.
